// File: rtl/pipe_hazard_pkg.sv
// Shared encodings and scoreboard entry type for the pipeline hazard controller.
package pipe_hazard_pkg;

  localparam logic [1:0] PCOP_PC4  = 2'b00;
  localparam logic [1:0] PCOP_ID   = 2'b01;
  localparam logic [1:0] PCOP_EX   = 2'b10;
  localparam logic [1:0] PCOP_HOLD = 2'b11;

  localparam int FWD_RF = 0;

  // Entry address field is sized for the widest supported register file;
  // narrower REG_AW values are zero-extended on entry and on compare.
  localparam int SB_AW_MAX = 8;

  typedef struct packed {
    logic                 v;
    logic                 ld;
    logic [SB_AW_MAX-1:0] wa;
  } sb_entry_t;

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Front-end <-> hazard controller bundle. The master side is the decode/fetch
// logic, the slave side is pipe_hazard_ctrl.
interface pipe_hazard_ctrl_if #(
  parameter int REG_AW = 5,
  parameter int NUM_RD = 2,
  parameter int FWD_W  = 2
);
  logic                     id_valid;
  logic [NUM_RD-1:0]        id_rd_en;
  logic [NUM_RD*REG_AW-1:0] id_rd_addr;
  logic                     id_wr_en;
  logic [REG_AW-1:0]        id_wr_addr;
  logic                     id_is_load;
  logic                     id_jump_direct;
  logic                     ex_redirect;
  logic [1:0]               pcop_o;
  logic                     stall_o;
  logic                     flush_if_o;
  logic                     flush_id_o;
  logic [NUM_RD*FWD_W-1:0]  fwd_sel_o;

  modport master (
    output id_valid, id_rd_en, id_rd_addr, id_wr_en, id_wr_addr,
    output id_is_load, id_jump_direct, ex_redirect,
    input  pcop_o, stall_o, flush_if_o, flush_id_o, fwd_sel_o
  );

  modport slave (
    input  id_valid, id_rd_en, id_rd_addr, id_wr_en, id_wr_addr,
    input  id_is_load, id_jump_direct, ex_redirect,
    output pcop_o, stall_o, flush_if_o, flush_id_o, fwd_sel_o
  );
endinterface

// File: rtl/hzd_sb_match.sv
// Youngest-match search of the in-flight destination scoreboard for one
// source port. Entry index 0 holds stage 1 (EX). The last stage is never
// reported because the register file writes through in that cycle.
module hzd_sb_match
  import pipe_hazard_pkg::*;
#(
  parameter int REG_AW = 5,
  parameter int DEPTH  = 3,
  parameter int FWD_W  = 2
) (
  input  logic                  rd_en,
  input  logic [REG_AW-1:0]     rd_addr,
  input  sb_entry_t [DEPTH-1:0] sb,
  output logic                  hit,
  output logic [FWD_W-1:0]      stage,
  output logic                  is_load
);

  // Scan oldest to youngest so the youngest matching stage is written last.
  always_comb begin
    hit     = 1'b0;
    stage   = '0;
    is_load = 1'b0;
    for (int s = DEPTH; s >= 1; s--) begin
      if ((s < DEPTH) && rd_en && (rd_addr != '0) && sb[s-1].v &&
          (sb[s-1].wa == SB_AW_MAX'(rd_addr))) begin
        hit     = 1'b1;
        stage   = FWD_W'(s);
        is_load = sb[s-1].ld;
      end
    end
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Parametrised hazard and forwarding controller for an in-order pipeline.
// Optional performance counters are enabled with PIPE_HAZARD_PERF_CNT_EN.
module pipe_hazard_ctrl
  import pipe_hazard_pkg::*;
#(
  parameter int REG_AW     = 5,
  parameter int NUM_RD     = 2,
  parameter int DEPTH      = 3,
  parameter int LOAD_STAGE = 3,
  parameter int FWD_W      = $clog2(DEPTH+1)
) (
  input  logic              clk,
  input  logic              rst,
  pipe_hazard_ctrl_if.slave hz
`ifdef PIPE_HAZARD_PERF_CNT_EN
  ,
  output logic [31:0]       perf_stall_cnt,
  output logic [31:0]       perf_flush_cnt,
  output logic [31:0]       perf_fwd_cnt
`endif
);

  sb_entry_t [DEPTH-1:0]   sb;
  sb_entry_t               sb_new;
  logic [NUM_RD-1:0]       hit;
  logic [FWD_W-1:0]        stg [NUM_RD];
  logic [NUM_RD-1:0]       ldm;
  logic                    load_use;
  logic                    stall;
  logic                    issue;
  logic [NUM_RD*FWD_W-1:0] fwd_next;
  logic [NUM_RD*FWD_W-1:0] fwd_sel_p1;

  for (genvar i = 0; i < NUM_RD; i++) begin : g_port
    hzd_sb_match #(
      .REG_AW (REG_AW),
      .DEPTH  (DEPTH),
      .FWD_W  (FWD_W)
    ) u_match (
      .rd_en   (hz.id_rd_en[i]),
      .rd_addr (hz.id_rd_addr[i*REG_AW +: REG_AW]),
      .sb      (sb),
      .hit     (hit[i]),
      .stage   (stg[i]),
      .is_load (ldm[i])
    );
  end

  // Load-use detection, front-end control priority and next forward selects.
  always_comb begin
    load_use = 1'b0;
    fwd_next = '0;
    for (int i = 0; i < NUM_RD; i++) begin
      if (hit[i] && ldm[i] && (int'(stg[i]) + 1 < LOAD_STAGE))
        load_use = 1'b1;
      if (hz.id_valid && hit[i])
        fwd_next[i*FWD_W +: FWD_W] = stg[i] + FWD_W'(1);
    end
    load_use = load_use & hz.id_valid;
    stall    = load_use & ~hz.ex_redirect;
    issue    = ~stall & ~hz.ex_redirect;

    sb_new.v  = issue & hz.id_valid & hz.id_wr_en & (hz.id_wr_addr != '0);
    sb_new.ld = hz.id_is_load;
    sb_new.wa = SB_AW_MAX'(hz.id_wr_addr);

    hz.pcop_o     = PCOP_PC4;
    hz.stall_o    = stall;
    hz.flush_if_o = 1'b0;
    hz.flush_id_o = 1'b0;
    if (hz.ex_redirect) begin
      hz.pcop_o     = PCOP_EX;
      hz.flush_if_o = 1'b1;
      hz.flush_id_o = 1'b1;
    end else if (stall) begin
      hz.pcop_o = PCOP_HOLD;
    end else if (hz.id_valid && hz.id_jump_direct) begin
      hz.pcop_o     = PCOP_ID;
      hz.flush_if_o = 1'b1;
    end
  end

  // Scoreboard shift and EX-aligned forward select register.
  always_ff @(posedge clk) begin
    sb[0] <= sb_new;
    for (int s = 1; s < DEPTH; s++)
      sb[s] <= sb[s-1];
    if (rst) begin
      for (int s = 0; s < DEPTH; s++)
        sb[s].v <= 1'b0;
      fwd_sel_p1 <= '0;
    end else begin
      fwd_sel_p1 <= issue ? fwd_next : '0;
    end
  end

  assign hz.fwd_sel_o = fwd_sel_p1;

`ifdef PIPE_HAZARD_PERF_CNT_EN
  // Saturating event counters: stall cycles, redirect cycles, forwarded issues.
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_stall_cnt <= '0;
      perf_flush_cnt <= '0;
      perf_fwd_cnt   <= '0;
    end else begin
      if (stall && (perf_stall_cnt != '1))
        perf_stall_cnt <= perf_stall_cnt + 32'd1;
      if (hz.ex_redirect && (perf_flush_cnt != '1))
        perf_flush_cnt <= perf_flush_cnt + 32'd1;
      if (issue && (fwd_next != '0) && (perf_fwd_cnt != '1))
        perf_fwd_cnt <= perf_fwd_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: each stimulus row queues its
// hand-computed outputs; a monitor on the falling edge pops and compares.
module tb_pipe_hazard_ctrl;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pipe_hazard_ctrl_if #(.REG_AW(5), .NUM_RD(2), .FWD_W(2)) hz ();

`ifdef PIPE_HAZARD_PERF_CNT_EN
  logic [31:0] perf_stall_cnt, perf_flush_cnt, perf_fwd_cnt;
`endif

  pipe_hazard_ctrl #(
    .REG_AW(5), .NUM_RD(2), .DEPTH(3), .LOAD_STAGE(3), .FWD_W(2)
  ) dut (
    .clk (clk),
    .rst (rst),
    .hz  (hz.slave)
`ifdef PIPE_HAZARD_PERF_CNT_EN
    ,
    .perf_stall_cnt (perf_stall_cnt),
    .perf_flush_cnt (perf_flush_cnt),
    .perf_fwd_cnt   (perf_fwd_cnt)
`endif
  );

  typedef struct {
    int         row;
    logic [1:0] pc;
    logic       st, fi, fd;
    logic [1:0] f0, f1;
  } exp_t;

  exp_t expq[$];
  int   tests  = 0;
  int   failed = 0;
  int   row    = 0;

  task automatic chk(input string name, input int r, input logic [1:0] act, input logic [1:0] req);
    tests++;
    if (act !== req) begin
      failed++;
      $display("FAIL row%0d %s: got %0d expected %0d", r, name, act, req);
    end
  endtask

  // Monitor: compare whatever the DUT shows against the oldest queued row.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (expq.size() > 0) begin
        e = expq.pop_front();
        chk("pcop",   e.row, hz.pcop_o, e.pc);
        chk("stall",  e.row, {1'b0, hz.stall_o}, {1'b0, e.st});
        chk("fl_if",  e.row, {1'b0, hz.flush_if_o}, {1'b0, e.fi});
        chk("fl_id",  e.row, {1'b0, hz.flush_id_o}, {1'b0, e.fd});
        chk("fwd0",   e.row, hz.fwd_sel_o[1:0], e.f0);
        chk("fwd1",   e.row, hz.fwd_sel_o[3:2], e.f1);
      end
    end
  end

  task automatic step(input logic r, input logic v, input logic [1:0] re,
                      input logic [4:0] a0, input logic [4:0] a1,
                      input logic we, input logic [4:0] wa, input logic ld,
                      input logic jd, input logic rx,
                      input logic [1:0] pc, input logic st, input logic fi,
                      input logic fd, input logic [1:0] f0, input logic [1:0] f1);
    exp_t e;
    @(posedge clk);
    #1;
    rst               = r;
    hz.id_valid       = v;
    hz.id_rd_en       = re;
    hz.id_rd_addr     = {a1, a0};
    hz.id_wr_en       = we;
    hz.id_wr_addr     = wa;
    hz.id_is_load     = ld;
    hz.id_jump_direct = jd;
    hz.ex_redirect    = rx;
    e.row = row; e.pc = pc; e.st = st; e.fi = fi; e.fd = fd; e.f0 = f0; e.f1 = f1;
    expq.push_back(e);
    row++;
  endtask

  task automatic idle(input logic [1:0] f0, input logic [1:0] f1);
    step(0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, f0, f1);
  endtask

  initial begin
    rst               = 1'b1;
    hz.id_valid       = 1'b0;
    hz.id_rd_en       = '0;
    hz.id_rd_addr     = '0;
    hz.id_wr_en       = 1'b0;
    hz.id_wr_addr     = '0;
    hz.id_is_load     = 1'b0;
    hz.id_jump_direct = 1'b0;
    hz.ex_redirect    = 1'b0;
    repeat (3) @(posedge clk);

    // reset state
    idle(0, 0);
    // back-to-back dependency on r3
    step(0, 1, 2'b00, 0, 0, 1, 3, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0);
    step(0, 1, 2'b01, 3, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0);
    idle(2, 0);
    idle(0, 0);
    // two apart: r4 read on port 1 -> 3
    step(0, 1, 2'b00, 0, 0, 1, 4, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0);
    step(0, 1, 2'b00, 0, 0, 1, 8, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0);
    step(0, 1, 2'b10, 0, 4, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0);
    idle(0, 3);
    // three apart: r9 is in the write-through stage -> 0
    step(0, 1, 2'b00, 0, 0, 1, 9, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0);
    step(0, 1, 2'b00, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0);
    step(0, 1, 2'b00, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0);
    step(0, 1, 2'b01, 9, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0);
    idle(0, 0);
    // load-use: lw r5; add r6,r5,r1
    step(0, 1, 2'b00, 0, 0, 1, 5, 1, 0, 0, 2'b00, 0, 0, 0, 0, 0);
    step(0, 1, 2'b11, 5, 1, 1, 6, 0, 0, 0, 2'b11, 1, 0, 0, 0, 0);
    step(0, 1, 2'b11, 5, 1, 1, 6, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0);
    idle(3, 0);
    idle(0, 0);
    idle(0, 0);
    // r0 write then r0 read
    step(0, 1, 2'b00, 0, 0, 1, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0);
    step(0, 1, 2'b01, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0);
    idle(0, 0);
    // two writers of r7: youngest (s=1) wins -> 2
    step(0, 1, 2'b00, 0, 0, 1, 7, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0);
    step(0, 1, 2'b00, 0, 0, 1, 7, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0);
    step(0, 1, 2'b10, 0, 7, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0);
    idle(0, 2);
    // redirect beats load-use stall and direct jump; killed ID never issues
    step(0, 1, 2'b00, 0, 0, 1, 10, 1, 0, 0, 2'b00, 0, 0, 0, 0, 0);
    step(0, 1, 2'b01, 10, 0, 1, 11, 0, 1, 1, 2'b10, 0, 1, 1, 0, 0);
    step(0, 1, 2'b11, 10, 11, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0);
    idle(3, 0);
    // direct jump alone
    step(0, 1, 2'b00, 0, 0, 0, 0, 0, 1, 0, 2'b01, 0, 1, 0, 0, 0);
    idle(0, 0);
    // stall beats direct jump, then jump proceeds
    step(0, 1, 2'b00, 0, 0, 1, 12, 1, 0, 0, 2'b00, 0, 0, 0, 0, 0);
    step(0, 1, 2'b01, 12, 0, 0, 0, 0, 1, 0, 2'b11, 1, 0, 0, 0, 0);
    step(0, 1, 2'b01, 12, 0, 0, 0, 0, 1, 0, 2'b01, 0, 1, 0, 0, 0);
    idle(3, 0);
    // reset in mid-stall with three live entries
    step(0, 1, 2'b00, 0, 0, 1, 13, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0);
    step(0, 1, 2'b00, 0, 0, 1, 14, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0);
    step(0, 1, 2'b00, 0, 0, 1, 15, 1, 0, 0, 2'b00, 0, 0, 0, 0, 0);
    step(1, 1, 2'b01, 15, 0, 0, 0, 0, 0, 0, 2'b11, 1, 0, 0, 0, 0);
    step(0, 1, 2'b11, 15, 14, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0);
    idle(0, 0);

    // drain: bounded wait for the monitor to consume every queued row
    for (int k = 0; k < 10 && expq.size() > 0; k++) @(posedge clk);
    if (expq.size() > 0) begin
      tests++;
      failed++;
      $display("FAIL drain: %0d rows left, required 0", expq.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
